proc_req_reg: RTL and testbench
===============================

Name: proc_req_reg

Overview:
- Registered processor-request front end for each L1 cache.
- Captures a processor read/write request (command, address, write data) and holds it stable on cmd_rd/cmd_wr/address for the address field splitter and the cache controller until the controller reports completion.
- Returns read data with a one-cycle acknowledge, then waits for the processor to withdraw its request before accepting another.

Parameters:
- ADDR_WID, 32, width of processor address.
- DATA_WID, 32, width of processor data word.
- TIMEOUT_CYC, 1024, cycles in ISSUE before watchdog abort; only used with PROC_REQ_TIMEOUT_EN; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_rd  input  1  processor read request, level, held until cpu_ack seen.
- cpu_wr  input  1  processor write request, level, held until cpu_ack seen.
- cpu_addr  input  ADDR_WID  processor address.
- cpu_wdata  input  DATA_WID  processor write data.
- cpu_ack  output  1  one-cycle pulse: request complete.
- cpu_rdata  output  DATA_WID  read data, valid from the cpu_ack cycle until the next accepted request.
- cmd_rd  output  1  registered read command to the splitter and controller.
- cmd_wr  output  1  registered write command to the splitter and controller.
- address  output  ADDR_WID  registered request address.
- wdata  output  DATA_WID  registered write data.
- ctrl_done  input  1  controller completion pulse; sampled only in ISSUE.
- ctrl_rdata  input  DATA_WID  controller read data, valid with ctrl_done.
- busy  output  1  high in ISSUE and RESP.
- timeout_err  output  1  sticky watchdog flag; tied 0 without PROC_REQ_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including cpu_rdata, address, wdata and timeout_err. Reset during ISSUE or RESP aborts with no cpu_ack.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - On (cpu_rd | cpu_wr), register addr/wdata/command and go to ISSUE.
  - cmd_* and address become visible the following cycle (1-cycle capture latency).
  - cpu_rd & cpu_wr together is treated as a read (cmd_rd=1, cmd_wr=0).
  - ctrl_done in IDLE is ignored.
- ISSUE:
  - cmd_*, address and wdata are held constant; cpu_addr/cpu_wdata changes are ignored.
  - On ctrl_done: cmd_rd=cmd_wr=0 next cycle; cpu_ack=1 for exactly that one cycle.
  - On a read, cpu_rdata<=ctrl_rdata; on a write, cpu_rdata is unchanged.
  - Go to RESP.
  - Minimum request-to-ack latency is 2 cycles (ctrl_done in the first ISSUE cycle).
- RESP:
  - Wait until cpu_rd=0 and cpu_wr=0, then go to IDLE. busy drops that same transition.
  - A new request needs at least one low cycle of both cpu_rd and cpu_wr; back-to-back held requests are not re-accepted.
- address and wdata retain their last value after completion. Downstream qualifies them with cmd_*.
- busy = (state != IDLE).

Optional Feature:
- Macro: PROC_REQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYC-1 with no ctrl_done, the request aborts: cmd_* drop, cpu_ack pulses, cpu_rdata is all ones on a read, timeout_err=1, and the state goes to RESP.
  - timeout_err clears when the next request is accepted in IDLE.
  - ctrl_done on the same cycle as expiry wins and the request completes normally.
- Undefined: no counter; ISSUE waits indefinitely; timeout_err is constant 0.

Test Plan:
- Read: cpu_rd=1, cpu_addr=0x0000_1A40. Next cycle cmd_rd=1, address=0x0000_1A40. ctrl_done with ctrl_rdata=0xDEAD_BEEF three cycles later. Expect cpu_ack for one cycle the following cycle, cpu_rdata=0xDEAD_BEEF, cmd_rd=0.
- Write: cpu_wr=1, cpu_wdata=0x1234_5678. Change cpu_addr/cpu_wdata mid-ISSUE. Expect wdata and address to stay at the captured values. After ctrl_done, expect cpu_ack and cpu_rdata unchanged.
- Handshake: keep cpu_rd high for 5 cycles after cpu_ack. Expect no new cmd_rd and busy=1. Drop cpu_rd. Expect IDLE and busy=0 next cycle, and a new request accepted after that.
- Simultaneous and illegal inputs: cpu_rd=cpu_wr=1 in IDLE gives cmd_rd=1, cmd_wr=0. ctrl_done pulsed in IDLE gives no cpu_ack.
- Reset mid-ISSUE: assert rst asynchronously between clock edges. Expect cmd_rd, busy and cpu_rdata to go 0 immediately, and no cpu_ack after release.
- Timeout (macro defined, TIMEOUT_CYC=8): read with no ctrl_done. Expect cpu_ack 8 cycles after cmd_rd rises, cpu_rdata=0xFFFF_FFFF and timeout_err=1. timeout_err clears on the next request.

Source files
------------

// File: rtl/proc_req_reg.sv
// proc_req_reg: registered processor-request front end for an L1 cache.
// Define PROC_REQ_TIMEOUT_EN to enable the ISSUE watchdog and timeout_err.
module proc_req_reg #(
  parameter int ADDR_WID    = 32,
  parameter int DATA_WID    = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_WID-1:0] cpu_addr,
  input  logic [DATA_WID-1:0] cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_WID-1:0] cpu_rdata,
  output logic                cmd_rd,
  output logic                cmd_wr,
  output logic [ADDR_WID-1:0] address,
  output logic [DATA_WID-1:0] wdata,
  input  logic                ctrl_done,
  input  logic [DATA_WID-1:0] ctrl_rdata,
  output logic                busy,
  output logic                timeout_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  if (TIMEOUT_CYC < 2) begin : g_chk
    $error("TIMEOUT_CYC must be >= 2");
  end
  logic [1:0] state;
  logic       req;
  logic       expire;
  assign req  = cpu_rd | cpu_wr;
  assign busy = state != IDLE;
`ifdef PROC_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic          terr;
  assign expire      = cnt == CW'(TIMEOUT_CYC - 1);
  assign timeout_err = terr;
  // cnt counts ISSUE cycles; cleared on request acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else if (state == IDLE && req) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else if (state == ISSUE) begin
      cnt  <= cnt + 1'b1;
      terr <= terr | (expire & ~ctrl_done);
    end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      address   <= '0;
      wdata     <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE:
          if (req) begin
            state   <= ISSUE;
            cmd_rd  <= cpu_rd;
            cmd_wr  <= cpu_wr & ~cpu_rd;
            address <= cpu_addr;
            wdata   <= cpu_wdata;
          end
        ISSUE:
          if (ctrl_done || expire) begin
            state   <= RESP;
            cmd_rd  <= 1'b0;
            cmd_wr  <= 1'b0;
            cpu_ack <= 1'b1;
            if (cmd_rd) cpu_rdata <= ctrl_done ? ctrl_rdata : '1;
          end
        RESP:
          if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_proc_req_reg.sv
// tb_proc_req_reg: directed self-checking bench with an expected-read-data scoreboard.
module tb_proc_req_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cmd_rd, cmd_wr;
  logic [31:0] address, wdata;
  logic        ctrl_done = 1'b0;
  logic [31:0] ctrl_rdata = '0;
  logic        busy, timeout_err;
  int          chk_cnt = 0, pass_cnt = 0, err_cnt = 0;
  logic [31:0] exp_q[$];

  proc_req_reg #(.ADDR_WID(32), .DATA_WID(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cmd_rd(cmd_rd),
    .cmd_wr(cmd_wr), .address(address), .wdata(wdata), .ctrl_done(ctrl_done),
    .ctrl_rdata(ctrl_rdata), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic done_pulse(logic [31:0] d);
    ctrl_done  = 1'b1;
    ctrl_rdata = d;
    step();
    ctrl_done  = 1'b0;
  endtask

  task automatic wait_ack(string tag);
    logic [31:0] e;
    int n = 0;
    while (!cpu_ack && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ack"}, cpu_ack, 1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hx;
    check({tag, "_rdata"}, cpu_rdata, e);
  endtask

  initial begin
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_cmd", {cmd_rd, cmd_wr, cpu_ack}, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b0;
    step();
    // read
    cpu_rd = 1'b1;
    cpu_addr = 32'h0000_1A40;
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    check("rd_cmd_rd", cmd_rd, 1);
    check("rd_addr", address, 32'h0000_1A40);
    check("rd_busy", busy, 1);
    step();
    step();
    check("rd_no_early_ack", cpu_ack, 0);
    done_pulse(32'hDEAD_BEEF);
    wait_ack("rd");
    check("rd_cmd_clr", cmd_rd, 0);
    // handshake: held request is not re-accepted
    for (int i = 0; i < 5; i++) begin
      step();
      check("hs_hold", {cmd_rd, cmd_wr, cpu_ack, busy}, 4'b0001);
    end
    check("hs_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    cpu_rd = 1'b0;
    step();
    check("hs_idle", busy, 0);
    // write with input changes mid-ISSUE
    cpu_wr = 1'b1;
    cpu_addr = 32'h0000_2000;
    cpu_wdata = 32'h1234_5678;
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    check("wr_cmd", {cmd_rd, cmd_wr}, 2'b01);
    check("wr_wdata", wdata, 32'h1234_5678);
    cpu_addr = 32'hFFFF_0000;
    cpu_wdata = 32'h0000_0000;
    step();
    check("wr_addr_hold", address, 32'h0000_2000);
    check("wr_wdata_hold", wdata, 32'h1234_5678);
    done_pulse(32'hCAFE_0000);
    wait_ack("wr");
    check("wr_cmd_clr", cmd_wr, 0);
    cpu_wr = 1'b0;
    step();
    check("wr_idle", busy, 0);
    check("wr_addr_keep", address, 32'h0000_2000);
    // simultaneous read and write
    cpu_rd = 1'b1;
    cpu_wr = 1'b1;
    cpu_addr = 32'h0000_0040;
    exp_q.push_back(32'h55AA_55AA);
    step();
    check("both_cmd", {cmd_rd, cmd_wr}, 2'b10);
    done_pulse(32'h55AA_55AA);
    wait_ack("both");
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    step();
    // ctrl_done while idle
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    check("idle_done_ack", cpu_ack, 0);
    check("idle_done_busy", busy, 0);
    step();
    check("idle_done_ack2", cpu_ack, 0);
    // async reset mid-ISSUE
    cpu_rd = 1'b1;
    cpu_addr = 32'h0000_0080;
    step();
    check("ar_cmd_pre", cmd_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_cmd", cmd_rd, 0);
    check("ar_busy", busy, 0);
    check("ar_rdata", cpu_rdata, 0);
    cpu_rd = 1'b0;
    step();
    rst = 1'b0;
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ar_no_ack", {cpu_ack, busy}, 0);
      step();
    end
    // normal read after reset
    cpu_rd = 1'b1;
    cpu_addr = 32'h0000_1000;
    exp_q.push_back(32'h0BAD_F00D);
    step();
    check("post_addr", address, 32'h0000_1000);
    done_pulse(32'h0BAD_F00D);
    wait_ack("post");
    cpu_rd = 1'b0;
    step();
`ifdef PROC_REQ_TIMEOUT_EN
    cpu_rd = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    step();
    check("to_cmd", cmd_rd, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("to_no_ack", cpu_ack, 0);
    end
    step();
    wait_ack("to");
    check("to_err", timeout_err, 1);
    check("to_cmd_clr", cmd_rd, 0);
    cpu_rd = 1'b0;
    step();
    check("to_err_sticky", timeout_err, 1);
    cpu_wr = 1'b1;
    step();
    check("to_err_clr", timeout_err, 0);
    done_pulse(32'h0);
    cpu_wr = 1'b0;
    step();
`else
    check("terr_tied", timeout_err, 0);
`endif
    check("q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
